// File: rtl/vending_machine.sv
// Drink vending controller.
// Coins add credit. A selection dispenses a drink once the credit covers its
// price. Any remaining credit is then returned as change. If the user drops the
// selection back to none while coins are held, the credit is refunded.
module vending_machine #(
  parameter int unsigned COIN_VALUE = 1,
  parameter int unsigned PRICE_1    = 2,
  parameter int unsigned PRICE_2    = 3,
  parameter int unsigned PRICE_3    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_inserted,
  input  logic [1:0] user_selection,
  output logic [3:0] balance,
  output logic [1:0] drink_dispensed
);

  typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;

  state_t     state;
  logic [3:0] credit;
  logic [1:0] prev_sel;
  logic [4:0] raw_sum;
  logic [3:0] sum;
  logic [3:0] price;

  function automatic logic [3:0] price_of(input logic [1:0] sel);
    case (sel)
      2'b01:   price_of = 4'(PRICE_1);
      2'b10:   price_of = 4'(PRICE_2);
      2'b11:   price_of = 4'(PRICE_3);
      default: price_of = 4'd0;
    endcase
  endfunction

  // Credit plus this edge's coin, saturating at 15; price of the current request
  always_comb begin
    raw_sum = {1'b0, credit} + (coin_inserted ? 5'(COIN_VALUE) : 5'd0);
    sum     = (raw_sum > 5'd15) ? 4'hF : raw_sum[3:0];
    price   = price_of(user_selection);
  end

  assign balance = credit;

  // Controller: collect coins, purchase / cancel, then dispense and return change
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      credit          <= 4'd0;
      prev_sel        <= 2'b00;
      drink_dispensed <= 2'b00;
    end else begin
      prev_sel <= user_selection;
      case (state)
        IDLE, COLLECT: begin
          if (user_selection != 2'b00 && sum >= price) begin
            credit          <= sum - price;
            drink_dispensed <= user_selection;
            state           <= DISPENSE;
          end else if (state == COLLECT && prev_sel != 2'b00 &&
                       user_selection == 2'b00) begin
            // A selection falling back to none counts as a cancel. Holding none does not.
            credit <= sum;
            state  <= CHANGE;
          end else begin
            credit <= sum;
            state  <= (sum != 4'd0) ? COLLECT : IDLE;
          end
        end
        DISPENSE: begin
          drink_dispensed <= 2'b00;
          state           <= (credit != 4'd0) ? CHANGE : IDLE;
        end
        CHANGE: begin
          // balance showed the returned amount for one cycle; the hopper has paid it
          credit <= 4'd0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vending_machine.sv
// Bench for vending_machine: directed test-plan scenarios plus a randomized run.
// Every cycle is compared against a behavioural model of the vending rules.
module tb_vending_machine;

  localparam int CV = 1, P1 = 2, P2 = 3, P3 = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       coin_inserted = 1'b0;
  logic [1:0] user_selection = 2'b00;
  logic [3:0] balance;
  logic [1:0] drink_dispensed;

  int n_cmp = 0;
  int n_err = 0;

  // Model state. "phase" counts the post-purchase busy cycles:
  // 0 = taking coins, 1 = drink out, 2 = handing back money.
  int m_credit = 0, m_drink = 0, m_prev = 0, m_phase = 0;

  vending_machine #(.COIN_VALUE(CV), .PRICE_1(P1), .PRICE_2(P2), .PRICE_3(P3)) dut (
    .clk(clk), .reset(reset), .coin_inserted(coin_inserted),
    .user_selection(user_selection), .balance(balance),
    .drink_dispensed(drink_dispensed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int price_of(input int sel);
    case (sel)
      1: return P1;
      2: return P2;
      3: return P3;
      default: return 0;
    endcase
  endfunction

  // Apply the vending rules for one clock edge.
  task automatic model_step(input int rst, input int coin, input int sel);
    int total;
    if (rst != 0) begin
      m_credit = 0; m_drink = 0; m_prev = 0; m_phase = 0;
      return;
    end
    case (m_phase)
      0: begin
        total = m_credit + (coin != 0 ? CV : 0);
        if (total > 15) total = 15;
        if (sel != 0 && total >= price_of(sel)) begin
          m_credit = total - price_of(sel);
          m_drink  = sel;
          m_phase  = 1;
        end else if (m_credit > 0 && m_prev != 0 && sel == 0) begin
          m_credit = total;
          m_phase  = 2;
        end else begin
          m_credit = total;
        end
      end
      1: begin
        m_drink = 0;
        m_phase = (m_credit > 0) ? 2 : 0;
      end
      default: begin
        m_credit = 0;
        m_phase  = 0;
      end
    endcase
    m_prev = sel;
  endtask

  // Drive one cycle, advance the model and compare both outputs after the edge.
  task automatic cyc(input int rst, input int coin, input int sel);
    reset          = (rst != 0);
    coin_inserted  = (coin != 0);
    user_selection = 2'(sel);
    @(posedge clk);
    model_step(rst, coin, sel);
    #1;
    chk("bal_model", int'(balance), m_credit);
    chk("drk_model", int'(drink_dispensed), m_drink);
  endtask

  initial begin
    int sel;
    // 1: reset, including coins held during reset
    cyc(1, 0, 0);
    chk("rst_bal", int'(balance), 0);
    chk("rst_drk", int'(drink_dispensed), 0);
    repeat (3) cyc(1, 1, 0);
    chk("rst_coin_bal", int'(balance), 0);

    // 2: accumulate without a selection, then hold the credit
    cyc(0, 1, 0); chk("t2_b1", int'(balance), 1);
    cyc(0, 1, 0); chk("t2_b2", int'(balance), 2);
    cyc(0, 1, 0); chk("t2_b3", int'(balance), 3);
    repeat (5) cyc(0, 0, 0);
    chk("t2_hold", int'(balance), 3);
    chk("t2_drk", int'(drink_dispensed), 0);

    // 3: exact payment for drink 01; a coin during dispense is ignored
    cyc(1, 0, 0);
    cyc(0, 1, 1);
    cyc(0, 1, 1);
    chk("t3_drk", int'(drink_dispensed), 1);
    chk("t3_bal", int'(balance), 0);
    cyc(0, 1, 1);
    chk("t3_after_drk", int'(drink_dispensed), 0);
    chk("t3_after_bal", int'(balance), 0);
    cyc(0, 0, 0);

    // 4: overpayment for drink 10 returns change
    cyc(1, 0, 0);
    repeat (4) cyc(0, 1, 0);
    chk("t4_bal4", int'(balance), 4);
    cyc(0, 0, 2);
    chk("t4_drk", int'(drink_dispensed), 2);
    chk("t4_bal1", int'(balance), 1);
    cyc(0, 0, 2);
    chk("t4_chg_drk", int'(drink_dispensed), 0);
    chk("t4_chg_bal", int'(balance), 1);
    cyc(0, 0, 0);
    chk("t4_idle_bal", int'(balance), 0);

    // 5: insufficient credit, then cancel refunds
    cyc(1, 0, 0);
    cyc(0, 1, 3);
    cyc(0, 1, 3);
    chk("t5_bal2", int'(balance), 2);
    chk("t5_nodrk", int'(drink_dispensed), 0);
    cyc(0, 0, 0);
    chk("t5_refund", int'(balance), 2);
    chk("t5_refund_drk", int'(drink_dispensed), 0);
    cyc(0, 0, 0);
    chk("t5_zero", int'(balance), 0);

    // 6: saturation, dispense from full credit, then reset mid-dispense
    cyc(1, 0, 0);
    repeat (17) cyc(0, 1, 0);
    chk("t6_sat", int'(balance), 15);
    cyc(0, 0, 3);
    chk("t6_drk", int'(drink_dispensed), 3);
    chk("t6_bal10", int'(balance), 10);
    cyc(0, 0, 3);
    chk("t6_chg", int'(balance), 10);
    cyc(0, 0, 0);
    chk("t6_zero", int'(balance), 0);
    repeat (17) cyc(0, 1, 0);
    cyc(0, 0, 3);
    chk("t6b_drk", int'(drink_dispensed), 3);
    cyc(1, 1, 3);
    chk("t6b_rst_bal", int'(balance), 0);
    chk("t6b_rst_drk", int'(drink_dispensed), 0);
    cyc(0, 0, 0);
    chk("t6b_idle", int'(balance), 0);

    // Randomized traffic: sticky selections, occasional resets
    sel = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) sel = $urandom_range(0, 3);
      cyc(($urandom_range(0, 99) == 0) ? 1 : 0, $urandom_range(0, 1), sel);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
